// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the TMDS serialiser gearbox.
// Holds the symbol width, the DVI control symbols, the clock-lane pattern and the slice-width check.
package tmds_pkg;

   localparam int TMDS_WORD_W = 10;

   // DVI control-period symbols; CTL0 doubles as the idle fill on an empty slot
   localparam logic [TMDS_WORD_W-1:0] CTL0 = 10'b1101010100;
   localparam logic [TMDS_WORD_W-1:0] CTL1 = 10'b0010101011;
   localparam logic [TMDS_WORD_W-1:0] CTL2 = 10'b0101010100;
   localparam logic [TMDS_WORD_W-1:0] CTL3 = 10'b1010101011;

   // Sent bit 0 first, this reads on the wire as 1111100000
   localparam logic [TMDS_WORD_W-1:0] CK_PATTERN = 10'b0000011111;

   function automatic bit legal_bpc(input int bpc);
      return (bpc == 1) || (bpc == 2) || (bpc == 5) || (bpc == 10);
   endfunction

endpackage

// File: rtl/tmds_lane_shifter.sv
// One output lane of the gearbox: loads a symbol and emits it BPC bits per cycle.
// The slot order is fixed at load time, so after loading the register always shifts toward bit 0.
module tmds_lane_shifter
   import tmds_pkg::*;
#(
   parameter int BPC       = 2,
   parameter int LSB_FIRST = 1,
   parameter bit INV       = 1'b0
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   load,
   input  logic [TMDS_WORD_W-1:0] sym,
   output logic [BPC-1:0]         bits
);

   logic [TMDS_WORD_W-1:0] sr_q;
   logic [TMDS_WORD_W-1:0] sr_d;
   logic [TMDS_WORD_W-1:0] ord;

   always_comb begin
      ord = '0;
      for (int i = 0; i < TMDS_WORD_W; i++) begin
         ord[i] = (LSB_FIRST != 0) ? sym[i] : sym[TMDS_WORD_W-1-i];
      end
   end

   always_comb begin
      sr_d = sr_q >> BPC;
      if (load) begin
         sr_d = ord;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   // Polarity swap is applied after slicing, so an inverted lane idles at all ones
   assign bits = sr_q[BPC-1:0] ^ {BPC{INV}};

endmodule

// File: rtl/tmds_gearbox.sv
// TMDS serialiser gearbox: per-lane 10-bit symbols in at pixel rate, BPC-bit slices out per fast clock.
// The phase counter, the load handshake and the sticky underflow flag live here.
module tmds_gearbox
   import tmds_pkg::*;
#(
   parameter int N_DATA_LANES = 3,
   parameter int BPC          = 2,
   parameter int CK_LANE_EN   = 1,
   parameter int LSB_FIRST    = 1,
   parameter logic [N_DATA_LANES+CK_LANE_EN-1:0] INV_MASK = '0
) (
   input  logic                                  CK,
   input  logic                                  SRST,
   input  logic [N_DATA_LANES*TMDS_WORD_W-1:0]   WORD_i,
   input  logic                                  WORD_VLD_i,
   output logic                                  WORD_RDY_o,
   output logic [(N_DATA_LANES+CK_LANE_EN)*BPC-1:0] BITS_o,
   output logic [3:0]                            PH_o,
   output logic                                  CKE_PIX_o,
   output logic                                  UNDERFLOW_o,
   input  logic                                  UF_CLR_i
);

   localparam int N_LANES = N_DATA_LANES + CK_LANE_EN;
   localparam int P       = TMDS_WORD_W / BPC;

   if (!legal_bpc(BPC)) begin : g_bad_bpc
      $error("tmds_gearbox: BPC must be 1, 2, 5 or 10");
   end

   logic [3:0] ph_q;
   logic [3:0] ph_d;
   logic       uf_q;
   logic       uf_d;
   logic       last_ph;
   logic       load;

   always_comb begin
      last_ph = (ph_q == 4'(P - 1));
      load    = last_ph && !SRST;
      ph_d    = last_ph ? 4'd0 : ph_q + 4'd1;
      uf_d    = uf_q;
      // A missed slot outranks a clear arriving in the same cycle
      if (load && !WORD_VLD_i) begin
         uf_d = 1'b1;
      end else if (UF_CLR_i) begin
         uf_d = 1'b0;
      end
   end

   always_ff @(posedge CK) begin
      if (SRST) begin
         ph_q <= '0;
         uf_q <= 1'b0;
      end else begin
         ph_q <= ph_d;
         uf_q <= uf_d;
      end
   end

   assign WORD_RDY_o  = load;
   assign CKE_PIX_o   = load;
   assign PH_o        = ph_q;
   assign UNDERFLOW_o = uf_q;

   for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      logic [TMDS_WORD_W-1:0] sym;

      if (k < N_DATA_LANES) begin : g_data
         assign sym = WORD_VLD_i ? WORD_i[k*TMDS_WORD_W +: TMDS_WORD_W] : CTL0;
      end else begin : g_clk
         assign sym = CK_PATTERN;
      end

      tmds_lane_shifter #(
         .BPC       (BPC),
         .LSB_FIRST (LSB_FIRST),
         .INV       (INV_MASK[k])
      ) u_lane (
         .clk  (CK),
         .srst (SRST),
         .load (load),
         .sym  (sym),
         .bits (BITS_o[k*BPC +: BPC])
      );
   end

endmodule

// File: doc/tmds_gearbox.md
Name: tmds_gearbox

Overview:
Parametrised TMDS serialiser gearbox for the DVI output path. It accepts one 10-bit TMDS symbol per data lane once per pixel period and slices each symbol into BPC-bit pieces per fast-clock cycle. The BITS_o slices feed the device DDR/LVDS output primitive. An optional clock lane carries the generated 1111100000 pixel-clock pattern. It generalises the fixed 3+1 lane, 2-bit, 5-phase arrangement to configurable lane count, slice width, bit order and per-lane polarity, and adds a ready/valid load handshake and underflow detection.

Parameters:
N_DATA_LANES, 3, number of TMDS data lanes (1..8)
BPC, 2, bits emitted per lane per CK cycle; legal values 1, 2, 5, 10; any other value is an elaboration error
CK_LANE_EN, 1, 1 = append a clock-pattern lane as the highest lane index
LSB_FIRST, 1, 1 = symbol bit 0 is transmitted first; 0 = bit 9 first
INV_MASK, 0, per-output-lane polarity inversion bitmask, width N_DATA_LANES+CK_LANE_EN

Ports:
CK  in  1  fast clock; one slice per lane per cycle
SRST  in  1  synchronous reset, active-high
WORD_i  in  N_DATA_LANES*10  TMDS symbols; lane k = WORD_i[k*10 +: 10]
WORD_VLD_i  in  1  WORD_i valid
WORD_RDY_o  out  1  gearbox loads on this cycle when WORD_VLD_i=1
BITS_o  out  (N_DATA_LANES+CK_LANE_EN)*BPC  lane k slice = BITS_o[k*BPC +: BPC]; slice bit 0 is the earlier bit (DDR high phase)
PH_o  out  4  current phase 0..P-1
CKE_PIX_o  out  1  pixel-rate enable, equal to WORD_RDY_o
UNDERFLOW_o  out  1  sticky: a load slot passed with WORD_VLD_i=0
UF_CLR_i  in  1  clears UNDERFLOW_o

Behaviour:
- P = 10/BPC phases per symbol. Phase counter PH runs 0..P-1 and wraps to 0.
- Reset (SRST=1, sampled on CK): next cycle PH=0, all shift registers=0, BITS_o=0, WORD_RDY_o=0, UNDERFLOW_o=0. Reset mid-word discards the word. A load coinciding with SRST is ignored.
- WORD_RDY_o = (PH==P-1) and not SRST. It is independent of WORD_VLD_i. No back-pressure: the slot is consumed whether or not valid is high.
- Load slot (PH==P-1):
  - WORD_VLD_i=1: each lane shift register loads its WORD_i symbol.
  - WORD_VLD_i=0: each data lane loads the idle control symbol CTL0 = 10'b1101010100, and UNDERFLOW_o is set next cycle.
  - The clock lane always loads CK_PATTERN = 10'b0000011111.
- Latency: a symbol accepted at cycle t (PH=P-1) appears on BITS_o in cycles t+1..t+P, slice i (i = 0..P-1) at t+1+i. BITS_o is registered.
- Slice i bit j = symbol bit (i*BPC+j) when LSB_FIRST=1, else symbol bit 9-(i*BPC+j).
- Output lane k is XORed with INV_MASK[k] after slicing, so inverted lanes show all ones in reset.
- The shift register shifts by BPC per cycle. The frame boundary is PH=0, identical on all lanes, so the clock lane is phase-aligned with data.
- Between reset release and the first load (P cycles), BITS_o = 0 (XOR INV_MASK).
- UNDERFLOW_o: set has priority over UF_CLR_i in the same cycle. UF_CLR_i alone clears it next cycle.
- BPC=10: P=1, WORD_RDY_o is high every non-reset cycle, and the whole symbol is output in one cycle.

Decomposition:
- Package tmds_pkg holds:
  - TMDS_WORD_W=10
  - CTL0..CTL3 symbols (1101010100, 0010101011, 0101010100, 1010101011)
  - CK_PATTERN
  - function legal_bpc()
- Sub-module tmds_lane_shifter (one per lane, generate loop): load, shift, slice, bit order and inversion for a single lane.
- The phase counter, handshake and underflow logic stay in the top.

Test Plan (N_DATA_LANES=3, BPC=2, P=5 unless noted):
1. Reset and startup: hold SRST 3 cycles, then release. BITS_o=0, PH_o=0 during reset. WORD_RDY_o first high at the 5th cycle after release (PH_o=4), then every 5 cycles.
2. Data load: lane0 = 10'h29C with VLD at RDY. Lane0 slices on the next 5 cycles are 0,3,1,2,2. Clock-lane slices are 3,3,1,0,0.
3. Underflow: VLD=0 at a RDY slot. Data lanes emit CTL0 (slices 0,1,1,1,3). UNDERFLOW_o=1 from the next cycle and holds until UF_CLR_i; after UF_CLR_i it reads 0.
4. Set/clear collision: UF_CLR_i=1 in the same cycle as an unfilled slot, so UNDERFLOW_o remains 1.
5. Variant LSB_FIRST=0, INV_MASK=4'b0001, lane0=10'h29C. Lane0 slices are ~{0b01,0b01,0b10,0b11,0b00} = 2,2,1,0,3, and reset output of lane0 = 2'b11.
6. SRST asserted at PH_o=2 mid-word. The next cycle shows BITS_o=0 and PH_o=0, and a RDY=1 coinciding with SRST does not load the word.
